spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_master.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// SPI master bus bundle: host handshake, data bytes and the four SPI pins.
// master modport faces the spi_master block, slave modport faces its user.
interface spi_master_if;
  localparam int unsigned DATA_W = 8;

  logic              start;
  logic              cpha;
  logic [DATA_W-1:0] masterDataIN;
  logic [DATA_W-1:0] masterDataOUT;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              cs;

  modport master (
    input  start, cpha, masterDataIN, miso,
    output masterDataOUT, busy, done, sclk, mosi, cs
  );

  modport slave (
    output start, cpha, masterDataIN, miso,
    input  masterDataOUT, busy, done, sclk, mosi, cs
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI master, MSB first, CPOL=0, per-transfer selectable CPHA.
// Frame: SETUP (CLK_DIV cycles) -> 16 sclk half-periods -> HOLD (CLK_DIV cycles).
// Optional feature macro: SPI_MASTER_LOOPBACK_EN adds a loopback input that
// feeds the internal mosi value into the receive sampler instead of miso.
module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic         loopback,
`endif
  spi_master_if.master bus
);

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned EDGE_W    = 5;
  localparam int unsigned NUM_EDGES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic                cpha_q;
  logic                sclk_q;
  logic                mosi_q;
  logic                cs_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   dout_q;
  logic                rx_bit_c;

  // Receive bit source: the pin, or the transmitted bit in loopback mode
`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit_c = loopback ? mosi_q : bus.miso;
`else
  assign rx_bit_c = bus.miso;
`endif

  assign bus.sclk          = sclk_q;
  assign bus.mosi          = mosi_q;
  assign bus.cs            = cs_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.masterDataOUT = dout_q;

  // Transfer sequencer: state, divider, edge counter, shifters and pin registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETUP;
            div_cnt  <= DIV_W'(CLK_DIV - 1);
            edge_cnt <= '0;
            tx_sr    <= bus.masterDataIN;
            rx_sr    <= '0;
            cpha_q   <= bus.cpha;
            mosi_q   <= bus.masterDataIN[DATA_W-1];
            sclk_q   <= 1'b0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        // SETUP is the first low half-period; both share the toggle logic
        SETUP, XFER: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else if (edge_cnt == EDGE_W'(NUM_EDGES)) begin
            state   <= HOLD;
            div_cnt <= DIV_W'(CLK_DIV - 1);
            sclk_q  <= 1'b0;
          end else begin
            state    <= XFER;
            div_cnt  <= DIV_W'(CLK_DIV - 1);
            edge_cnt <= edge_cnt + EDGE_W'(1);
            sclk_q   <= ~sclk_q;
            if (!sclk_q) begin
              // rising edge
              if (cpha_q) begin
                mosi_q <= tx_sr[DATA_W-1];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
              end else begin
                rx_sr  <= {rx_sr[DATA_W-2:0], rx_bit_c};
              end
            end else begin
              // falling edge
              if (cpha_q) begin
                rx_sr  <= {rx_sr[DATA_W-2:0], rx_bit_c};
              end else begin
                mosi_q <= tx_sr[DATA_W-2];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
        end

        HOLD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            state  <= IDLE;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dout_q <= rx_sr;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
